// File: rtl/osd_text_writer_if.sv
// Command stream from the debugger control logic into the OSD text writer.
// The master drives a command and the slave signals acceptance with cmd_ready.
interface osd_text_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [5:0] cmd_col;
  logic [4:0] cmd_row;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row, output cmd_ready);
endinterface

// File: rtl/osd_text_writer.sv
// Fills the OSD character RAM (port A) from a command stream and runs the
// frame-count timer that drives the overlay's osd_active enable.
module osd_text_writer #(
  parameter int              SCREEN_COLS    = 40,
  parameter int              SCREEN_ROWS    = 30,
  parameter int              ADDR_W         = 11,
  parameter logic [7:0]      CLEAR_CHAR     = 8'h20,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vblank,
  osd_text_writer_if.slave   cmd,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [7:0]         ram_data,
  output logic [5:0]         cursor_col,
  output logic [4:0]         cursor_row,
  output logic               busy,
  output logic               osd_active
);

  localparam int                TOTAL     = SCREEN_COLS * SCREEN_ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [5:0]        COL_MAX   = 6'(SCREEN_COLS - 1);
  localparam logic [4:0]        ROW_MAX   = 5'(SCREEN_ROWS - 1);
  localparam logic [1:0]        OP_PUTC   = 2'd0;
  localparam logic [1:0]        OP_SETCUR = 2'd1;
  localparam logic [1:0]        OP_CLEAR  = 2'd2;
  localparam logic [1:0]        OP_SHOW   = 2'd3;

  generate
    if (TOTAL > (1 << ADDR_W) || SCREEN_COLS > 64 || SCREEN_ROWS > 32) begin : g_bad_geometry
      $error("osd_text_writer: screen geometry does not fit the address or cursor width");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [5:0]        col_reg, col_next;
  logic [4:0]        row_reg, row_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [7:0]        ram_data_reg, ram_data_next;
  logic [7:0]        frame_cnt_reg, frame_cnt_next;
  logic              osd_active_reg;
  logic              vblank_reg;
  logic              ready_reg;
  logic              busy_reg;

  logic              accept;
  logic              vblank_rise;
  logic [4:0]        row_inc;
  logic [ADDR_W-1:0] cursor_addr;

  assign accept      = cmd.cmd_valid & ready_reg;
  assign vblank_rise = vblank & ~vblank_reg;
  assign row_inc     = (row_reg == ROW_MAX) ? 5'd0 : row_reg + 5'd1;
  assign cursor_addr = ADDR_W'(row_reg) * ADDR_W'(SCREEN_COLS) + ADDR_W'(col_reg);

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    clr_addr_next  = clr_addr_reg;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_data_next  = ram_data_reg;
    frame_cnt_next = frame_cnt_reg;

    // A SHOW load takes priority over a coincident vblank decrement.
    if (accept && cmd.cmd_op == OP_SHOW) begin
      frame_cnt_next = cmd.cmd_data;
    end else if (vblank_rise && frame_cnt_reg != 8'd0) begin
      frame_cnt_next = frame_cnt_reg - 8'd1;
    end

    case (state_reg)
      ST_CLEAR: begin
        ram_we_next   = 1'b1;
        ram_addr_next = clr_addr_reg;
        ram_data_next = CLEAR_CHAR;
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          col_next   = 6'd0;
          row_next   = 5'd0;
        end
      end
      default: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_PUTC: begin
              if (cmd.cmd_data == 8'h0A) begin
                col_next = 6'd0;
                row_next = row_inc;
              end else begin
                ram_we_next   = 1'b1;
                ram_addr_next = cursor_addr;
                ram_data_next = cmd.cmd_data;
                if (col_reg == COL_MAX) begin
                  col_next = 6'd0;
                  row_next = row_inc;
                end else begin
                  col_next = col_reg + 6'd1;
                end
              end
            end
            OP_SETCUR: begin
              col_next = (cmd.cmd_col > COL_MAX) ? COL_MAX : cmd.cmd_col;
              row_next = (cmd.cmd_row > ROW_MAX) ? ROW_MAX : cmd.cmd_row;
            end
            OP_CLEAR: begin
              state_next    = ST_CLEAR;
              clr_addr_next = '0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // ready/busy are registered so both read 0 while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      col_reg        <= 6'd0;
      row_reg        <= 5'd0;
      clr_addr_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= 8'd0;
      frame_cnt_reg  <= 8'd0;
      osd_active_reg <= 1'b0;
      vblank_reg     <= 1'b0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      clr_addr_reg   <= clr_addr_next;
      ram_we_reg     <= ram_we_next;
      ram_addr_reg   <= ram_addr_next;
      ram_data_reg   <= ram_data_next;
      frame_cnt_reg  <= frame_cnt_next;
      osd_active_reg <= (frame_cnt_reg != 8'd0);
      vblank_reg     <= vblank;
      ready_reg      <= (state_next == ST_IDLE);
      busy_reg       <= (state_next == ST_CLEAR);
    end
  end

  assign cmd.cmd_ready = ready_reg;
  assign ram_we        = ram_we_reg;
  assign ram_addr      = ram_addr_reg;
  assign ram_data      = ram_data_reg;
  assign cursor_col    = col_reg;
  assign cursor_row    = row_reg;
  assign busy          = busy_reg;
  assign osd_active    = osd_active_reg;

endmodule
